// File: rtl/fetcher_param.sv
// fetcher_param: fetches one instruction of 1..MAX_LEN bytes from a ROM of ROM_LAT cycles read latency.
// Latency len*ROM_LAT+1 cycles from the start edge to the done pulse; not pipelined, one fetch in flight.
// Optional macro FETCHER_WRAP_ERR_EN: end the fetch with err when it would run past the top address.
module fetcher_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MAX_LEN  = 3,
  parameter int LEN_BITS = 2,
  parameter int ROM_LAT  = 1
) (
  input  logic                      clk_tb,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [ADDR_W-1:0]         icp_value,
  input  logic [DATA_W-1:0]         rom_data_in,
  output logic [ADDR_W-1:0]         ecp_value,
  output logic [MAX_LEN*DATA_W-1:0] data_out,
  output logic [2:0]                len_out,
  output logic                      done,
  output logic                      err,
  output logic                      inhibit_cpu,
  output logic                      fetcher_inhibitted
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         ecp_q;
  logic [MAX_LEN*DATA_W-1:0] data_q;
  logic [2:0]                len_q;
  logic [1:0]                k;
  logic [1:0]                lat_cnt;
  logic                      capture;
  logic                      last;
  logic                      wrap_hit;
  logic [4:0]                field_p1;
  logic [2:0]                dec_len;
  logic [2:0]                cur_len;

  // Opcode length decode is only meaningful on the capture of byte 0.
  always_comb begin
    field_p1 = 5'(rom_data_in[DATA_W-1 -: LEN_BITS]) + 5'd1;
    dec_len  = (field_p1 > 5'(MAX_LEN)) ? 3'(MAX_LEN) : field_p1[2:0];
    cur_len  = (k == 2'd0) ? dec_len : len_q;
    capture  = (state == FETCH) && (lat_cnt == LAT_LAST);
    last     = (({1'b0, k} + 3'd1) == cur_len);
  end

`ifdef FETCHER_WRAP_ERR_EN
  logic err_q;
  assign wrap_hit = (ecp_q == {ADDR_W{1'b1}}) && !last;
  assign err      = err_q;
`else
  assign wrap_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk_tb or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FETCH;
      FETCH:   if (capture && (last || wrap_hit)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      ecp_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      k       <= '0;
      lat_cnt <= '0;
`ifdef FETCHER_WRAP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else if (state == IDLE && enable) begin
      ecp_q   <= icp_value;
      data_q  <= '0;
      k       <= '0;
      lat_cnt <= '0;
`ifdef FETCHER_WRAP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else if (capture) begin
      data_q[k*DATA_W +: DATA_W] <= rom_data_in;
      ecp_q   <= ecp_q + ADDR_W'(1);
      lat_cnt <= '0;
      k       <= k + 2'd1;
      if (k == 2'd0) len_q <= dec_len;
`ifdef FETCHER_WRAP_ERR_EN
      err_q   <= wrap_hit;
`endif
    end else if (state == FETCH) begin
      lat_cnt <= lat_cnt + 2'd1;
    end
  end

  assign ecp_value          = ecp_q;
  assign data_out           = data_q;
  assign len_out            = len_q;
  assign done               = (state == DONE);
  assign inhibit_cpu        = (state != IDLE);
  assign fetcher_inhibitted = (state == IDLE) && !enable;

endmodule

// File: doc/fetcher_param.md
FETCHER_PARAM -- requirements
Module: fetcher_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: ROM word and instruction byte width.
REQ-002 SHALL have parameter ADDR_W, default 8: code pointer width.
REQ-003 SHALL have parameter MAX_LEN, default 3, legal range 1..4: maximum instruction length in bytes.
REQ-004 SHALL have parameter LEN_BITS, default 2: width of the opcode length field in opcode[DATA_W-1 -: LEN_BITS].
REQ-005 SHALL have parameter ROM_LAT, default 1, legal range 1..4: ROM read latency in cycles.
REQ-006 SHALL have port clk_tb, input, width 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, width 1: fetch request, sampled only in IDLE.
REQ-009 SHALL have port icp_value, input, width ADDR_W: start address of the instruction.
REQ-010 SHALL have port rom_data_in, input, width DATA_W: ROM read data.
REQ-011 SHALL have port ecp_value, output, width ADDR_W: registered ROM address.
REQ-012 SHALL have port data_out, output, width MAX_LEN*DATA_W: byte k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port len_out, output, width 3: length of the fetched instruction.
REQ-014 SHALL have port done, output, width 1: one-cycle completion pulse.
REQ-015 SHALL have port err, output, width 1: wrap error, valid with done.
REQ-016 SHALL have port inhibit_cpu, output, width 1: CPU stall request.
REQ-017 SHALL have port fetcher_inhibitted, output, width 1: high while in IDLE with enable low.

Function
REQ-018 SHALL implement states IDLE, FETCH and DONE.
REQ-019 IDLE -> FETCH at edge T0 when enable=1; at that edge icp_value SHALL be loaded into ecp_value, data_out SHALL be cleared and the byte counter k SHALL be set to 0.
REQ-020 In FETCH, byte k SHALL be captured from rom_data_in at edge T0+(k+1)*ROM_LAT, and ecp_value SHALL increment at the same edge; each address is held for exactly ROM_LAT cycles, and fetches are not pipelined.
REQ-021 After byte 0 is captured, len = min(opcode length field + 1, MAX_LEN); len SHALL be registered to len_out at that edge.
REQ-022 After byte len-1 is captured, the block SHALL go FETCH -> DONE; done=1 for exactly one cycle in DONE, then DONE -> IDLE.
REQ-023 If enable is still high in IDLE after DONE, a new fetch SHALL start at the next edge and re-sample icp_value; back-to-back period = len*ROM_LAT+2 cycles.
REQ-024 data_out, len_out and err SHALL hold their values from DONE until the next IDLE -> FETCH edge; bytes at index >= len SHALL read 0.
REQ-025 inhibit_cpu SHALL equal 1 in FETCH and DONE and 0 in IDLE, registered with the state.
REQ-026 Deasserting enable during FETCH SHALL NOT abort the fetch.
REQ-027 ecp_value SHALL increment modulo 2^ADDR_W.

Reset
REQ-028 While rst=1, the block SHALL be in IDLE with ecp_value=0, data_out=0, len_out=0, done=0, err=0, inhibit_cpu=0 and k=0, asynchronously, including when reset occurs mid-fetch.
REQ-029 After rst deasserts, the block SHALL start a fetch at the first rising edge on which enable=1.

Configuration
REQ-030 With macro FETCHER_WRAP_ERR_EN defined, the first capture at address 2^ADDR_W-1 with bytes still outstanding SHALL end the fetch: transition to DONE with err=1, len_out still equal to the decoded len, and the remaining bytes 0.
REQ-031 Without FETCHER_WRAP_ERR_EN, err SHALL be tied to 0 and the fetch SHALL continue across the address wrap to 0.

Verification
REQ-032 Defaults, ROM_LAT=1, icp=0x10, ROM[0x10]=0x80 (field 2 -> len 3), ROM[0x11]=0xAB, ROM[0x12]=0xCD -> captures at T0+1..T0+3, done at cycle T0+4, data_out=0xCDAB80, len_out=3, inhibit_cpu high cycles T0+1..T0+4.
REQ-033 ROM[0x20]=0x05 (len 1), enable held high -> done after 1 byte, data_out=0x000005; a second fetch starts at the cycle after IDLE is entered with a re-sampled icp_value.
REQ-034 ROM_LAT=3, opcode 0x40 (len 2) -> ecp_value holds each address for 3 cycles, bytes captured at T0+3 and T0+6, done at cycle T0+7.
REQ-035 Opcode field 3 with MAX_LEN=3 -> len clamped to 3; with MAX_LEN=4 -> len 4 and 4 bytes fetched.
REQ-036 icp=0xFE, len 3: with FETCHER_WRAP_ERR_EN -> err=1, data_out[23:16]=0; without the macro -> bytes read from 0xFE, 0xFF, 0x00 and err=0.
REQ-037 rst pulsed after byte 1 of a 3-byte fetch -> all outputs return to 0 immediately and no done pulse occurs; a new fetch after release completes normally.
